// File: rtl/aes_req_sched_if.sv
// aes_req_sched_if: requester, response, core and status signals of the AES request scheduler
// master: scheduler side (drives req_ready, rsp_*, core_ld/key/text, busy)
// slave:  environment side (drives req_valid/key/text, rsp_ready, core_done/text_out)
interface aes_req_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*128-1:0] req_key;
    logic [NREQ*128-1:0] req_text;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [127:0]        rsp_data;
    logic                rsp_err;
    logic                core_ld;
    logic [127:0]        core_key;
    logic [127:0]        core_text;
    logic                core_done;
    logic [127:0]        core_text_out;
    logic                busy;
    modport master (
        input  req_valid, req_key, req_text, rsp_ready, core_done, core_text_out,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, core_ld, core_key, core_text, busy
    );
    modport slave (
        output req_valid, req_key, req_text, rsp_ready, core_done, core_text_out,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, core_ld, core_key, core_text, busy
    );
endinterface

// File: rtl/aes_req_sched.sv
// aes_req_sched: round-robin scheduler sharing one AES-128 core among NREQ requesters
// clk, rst (synchronous, active-low); bus (master): req_valid/req_ready/req_key/req_text in,
// rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_err out, core_ld/core_key/core_text to the core,
// core_done/core_text_out from the core, busy high outside IDLE.
module aes_req_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 3,
    parameter int TIMEOUT = 16
) (
    input logic            clk,
    input logic            rst,
    aes_req_sched_if.master bus
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    typedef enum logic [1:0] {IDLE, LOAD, BUSY, RESP} state_t;
    state_t          state, nxt;
    logic [IDW-1:0]  rr_ptr, gnt, cur_id;
    logic [NREQ-1:0] rot;
    logic            found, expired;
    logic [127:0]    sel_key, sel_text;
    logic [CW-1:0]   cnt;
    // rotate valids so bit 0 is the requester at rr_ptr; the lowest set bit wins
    always_comb begin
        rot = NREQ'({bus.req_valid, bus.req_valid} >> rr_ptr);
        found = 1'b0;
        gnt = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                gnt = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
        sel_key = '0;
        sel_text = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt == IDW'(k)) begin
                sel_key = bus.req_key[128*k +: 128];
                sel_text = bus.req_text[128*k +: 128];
            end
        end
    end
    assign expired = cnt == CW'(TIMEOUT - 1);
    always_comb begin
        nxt = state;
        nxt = state == IDLE ? (found ? LOAD : IDLE) :
              state == LOAD ? BUSY :
              state == BUSY ? ((bus.core_done || expired) ? RESP : BUSY) :
                              (bus.rsp_ready ? IDLE : RESP);
    end
    // grant is gated by rst so nothing is offered while the capture is being reset
    assign bus.req_ready = (rst && state == IDLE && found) ? NREQ'(1) << gnt : '0;
    assign bus.core_ld   = state == LOAD;
    assign bus.rsp_valid = state == RESP;
    assign bus.busy      = state != IDLE;
    assign bus.rsp_id    = cur_id;
    always_ff @(posedge clk) state <= !rst ? IDLE : nxt;
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr        <= '0;
            cur_id        <= '0;
            cnt           <= '0;
            bus.core_key  <= '0;
            bus.core_text <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && found) begin
                bus.core_key  <= sel_key;
                bus.core_text <= sel_text;
                cur_id        <= gnt;
                rr_ptr        <= gnt == IDW'(NREQ - 1) ? '0 : gnt + 1'b1;
            end
            if (state == LOAD) cnt <= '0;
            if (state == BUSY) begin
                if (bus.core_done) begin
                    bus.rsp_data <= bus.core_text_out;
                    bus.rsp_err  <= 1'b0;
                end else if (expired) begin
                    bus.rsp_data <= '0;
                    bus.rsp_err  <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_req_sched.sv
// tb_aes_req_sched: randomized and directed self-checking bench for aes_req_sched
module tb_aes_req_sched;
    localparam int NREQ = 4, IDW = 3, TIMEOUT = 16;
    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    logic clk = 0, rst = 0;
    always #5 clk = ~clk;
    aes_req_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
    aes_req_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));
    int errors = 0, checks = 0;
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // stand-in cipher: real AES for the known vector, a keyed mix otherwise
    function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] t);
        return (k == FIPS_K && t == FIPS_P) ? FIPS_C : k ^ {t[63:0], t[127:64]} ^ 128'hc3a5_5a3c_0f1e_e1f0_9669_6996_a5c3_3c5a;
    endfunction
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    // core model: done 12 cycles after ld unless withheld; spur forces a stray pulse
    int dn = 0;
    logic hold_done = 0, spur = 0;
    logic [127:0] ck = 0, ct = 0;
    always @(posedge clk) begin
        if (!rst) begin
            dn <= 0;
            bus.core_done <= 1'b0;
            bus.core_text_out <= '0;
        end else begin
            if (bus.core_ld) begin
                dn <= 12;
                ck <= bus.core_key;
                ct <= bus.core_text;
            end else if (dn != 0) dn <= dn - 1;
            bus.core_done <= (dn == 2 && !hold_done) || spur;
            bus.core_text_out <= cipher(ck, ct);
        end
    end
    // transaction-level reference: one job in flight, fixed latencies, round-robin grant
    int cyc = 0, m_ptr = 0, m_acc = 0, m_rsp_at = 0, m_id = 0, g, gi;
    bit m_free = 1, m_err = 0;
    logic [127:0] m_exp = 0, m_key = 0, m_text = 0;
    logic [NREQ-1:0] er;
    int acc_id[$], acc_t[$], acc_n[$], rsp_id_q[$], rsp_t_q[$];
    logic [127:0] rsp_d_q[$];
    bit rsp_e_q[$];
    always @(negedge clk) begin
        er = '0;
        g = -1;
        if (rst && m_free)
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && bus.req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 128'(bus.req_ready), 128'(er));
        chk("core_ld", 128'(bus.core_ld), 128'(!m_free && cyc == m_acc + 1));
        chk("busy", 128'(bus.busy), 128'(!m_free));
        chk("rsp_valid", 128'(bus.rsp_valid), 128'(!m_free && cyc >= m_rsp_at));
        chk("core_key", bus.core_key, m_key);
        chk("core_text", bus.core_text, m_text);
        if (!m_free && cyc >= m_rsp_at) begin
            chk("rsp_id", 128'(bus.rsp_id), 128'(m_id));
            chk("rsp_data", bus.rsp_data, m_exp);
            chk("rsp_err", 128'(bus.rsp_err), 128'(m_err));
        end
        if ((bus.req_valid & bus.req_ready) != 0) begin
            gi = 0;
            for (int k = NREQ - 1; k >= 0; k--) if (bus.req_valid[k] && bus.req_ready[k]) gi = k;
            acc_id.push_back(gi);
            acc_t.push_back(cyc);
            acc_n.push_back($countones(bus.req_ready));
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            rsp_id_q.push_back(int'(bus.rsp_id));
            rsp_t_q.push_back(cyc);
            rsp_d_q.push_back(bus.rsp_data);
            rsp_e_q.push_back(bus.rsp_err);
        end
        if (!rst) begin
            m_free = 1;
            m_ptr = 0;
            m_key = 0;
            m_text = 0;
        end else if (!m_free) begin
            if (cyc >= m_rsp_at && bus.rsp_ready) m_free = 1;
        end else if (g >= 0) begin
            m_free = 0;
            m_acc = cyc;
            m_id = g;
            m_ptr = (g + 1) % NREQ;
            m_key = bus.req_key[128*g +: 128];
            m_text = bus.req_text[128*g +: 128];
            m_err = hold_done;
            m_exp = hold_done ? '0 : cipher(m_key, m_text);
            m_rsp_at = hold_done ? cyc + TIMEOUT + 2 : cyc + 14;
        end
        cyc++;
    end
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic set_req(input int i, input logic [127:0] k, input logic [127:0] t);
        bus.req_key[128*i +: 128] = k;
        bus.req_text[128*i +: 128] = t;
    endtask
    task automatic wait_acc(input string tag);
        int n0 = acc_id.size();
        for (int i = 0; i < 60 && acc_id.size() == n0; i++) step(1);
        chk(tag, 128'(acc_id.size()), 128'(n0 + 1));
    endtask
    task automatic wait_rsp(input string tag);
        int n0 = rsp_id_q.size();
        for (int i = 0; i < 60 && rsp_id_q.size() == n0; i++) step(1);
        chk(tag, 128'(rsp_id_q.size()), 128'(n0 + 1));
    endtask
    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60 && bus.busy; i++) step(1);
        chk(tag, 128'(bus.busy), 128'(0));
    endtask
    initial begin
        int n0, r;
        logic [127:0] k1, t1;
        bus.req_valid = '0;
        bus.req_key = '0;
        bus.req_text = '0;
        bus.rsp_ready = 1'b1;
        step(3);
        chk("rst_busy", 128'(bus.busy), 0);
        chk("rst_rsp_valid", 128'(bus.rsp_valid), 0);
        chk("rst_rsp_id", 128'(bus.rsp_id), 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_core_key", bus.core_key, 0);
        rst = 1;
        step(2);
        // known-answer single request from requester 2
        set_req(2, FIPS_K, FIPS_P);
        bus.req_valid = 4'b0100;
        wait_acc("t1_accept");
        bus.req_valid = '0;
        wait_rsp("t1_response");
        chk("t1_acc_id", 128'(acc_id[$]), 2);
        chk("t1_rsp_id", 128'(rsp_id_q[$]), 2);
        chk("t1_rsp_data", rsp_d_q[$], FIPS_C);
        chk("t1_rsp_err", 128'(rsp_e_q[$]), 0);
        chk("t1_latency", 128'(rsp_t_q[$] - acc_t[$]), 14);
        // all requesters continuously valid from a fresh pointer
        rst = 0;
        step(2);
        rst = 1;
        for (int i = 0; i < NREQ; i++) set_req(i, rnd128(), rnd128());
        n0 = acc_id.size();
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 100 && acc_id.size() < n0 + 5; i++) step(1);
        bus.req_valid = '0;
        chk("t2_accepts", 128'(acc_id.size() - n0), 5);
        for (int j = 0; j < 5 && n0 + j < acc_id.size(); j++) begin
            chk("t2_rr_order", 128'(acc_id[n0+j]), 128'(j % 4));
            chk("t2_onehot", 128'(acc_n[n0+j]), 1);
            if (j > 0) chk("t2_spacing", 128'(acc_t[n0+j] - acc_t[n0+j-1]), 15);
        end
        wait_idle("t2_idle");
        // backpressure while requester 1 waits
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0001;
        wait_acc("t3_accept0");
        chk("t3_acc_id", 128'(acc_id[$]), 0);
        bus.req_valid = 4'b0010;
        for (int i = 0; i < 40 && !bus.rsp_valid; i++) step(1);
        chk("t3_rsp_valid", 128'(bus.rsp_valid), 1);
        step(20);
        bus.rsp_ready = 1'b1;
        r = cyc;
        wait_acc("t3_accept1");
        chk("t3_grant_id", 128'(acc_id[$]), 1);
        chk("t3_grant_cycle", 128'(acc_t[$]), 128'(r + 1));
        bus.req_valid = '0;
        wait_idle("t3_idle");
        // timeout, then a normal completion
        hold_done = 1;
        set_req(3, rnd128(), rnd128());
        bus.req_valid = 4'b1000;
        wait_acc("t4_accept");
        bus.req_valid = '0;
        wait_rsp("t4_response");
        chk("t4_err", 128'(rsp_e_q[$]), 1);
        chk("t4_data", rsp_d_q[$], 0);
        chk("t4_latency", 128'(rsp_t_q[$] - acc_t[$]), 128'(TIMEOUT + 2));
        hold_done = 0;
        k1 = rnd128();
        t1 = rnd128();
        set_req(1, k1, t1);
        bus.req_valid = 4'b0010;
        wait_acc("t4_accept_ok");
        bus.req_valid = '0;
        wait_rsp("t4_response_ok");
        chk("t4_ok_err", 128'(rsp_e_q[$]), 0);
        chk("t4_ok_data", rsp_d_q[$], cipher(k1, t1));
        wait_idle("t4_idle");
        // stray core_done while idle
        n0 = rsp_id_q.size();
        spur = 1;
        step(1);
        spur = 0;
        step(4);
        chk("t5_no_rsp", 128'(rsp_id_q.size()), 128'(n0));
        chk("t5_busy", 128'(bus.busy), 0);
        // reset in BUSY, late done ignored, pointer back to 0
        set_req(2, rnd128(), rnd128());
        bus.req_valid = 4'b0100;
        wait_acc("t6_accept");
        bus.req_valid = '0;
        step(4);
        rst = 0;
        step(1);
        chk("t6_busy", 128'(bus.busy), 0);
        chk("t6_rsp_valid", 128'(bus.rsp_valid), 0);
        chk("t6_core_ld", 128'(bus.core_ld), 0);
        chk("t6_req_ready", 128'(bus.req_ready), 0);
        chk("t6_core_key", bus.core_key, 0);
        chk("t6_core_text", bus.core_text, 0);
        chk("t6_rsp_id", 128'(bus.rsp_id), 0);
        chk("t6_rsp_data", bus.rsp_data, 0);
        chk("t6_rsp_err", 128'(bus.rsp_err), 0);
        rst = 1;
        n0 = rsp_id_q.size();
        step(6);
        spur = 1;
        step(1);
        spur = 0;
        step(4);
        chk("t6_no_rsp", 128'(rsp_id_q.size()), 128'(n0));
        bus.req_valid = 4'b1111;
        wait_acc("t6_accept_after");
        chk("t6_first_grant", 128'(acc_id[$]), 0);
        bus.req_valid = '0;
        wait_idle("t6_idle");
        // random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            bus.req_valid = NREQ'($urandom_range(0, 15));
            bus.rsp_ready = $urandom_range(0, 3) != 0;
            for (int j = 0; j < NREQ; j++) set_req(j, rnd128(), rnd128());
            step(1);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        wait_idle("t7_idle");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aes_req_sched.md
# aes_req_sched

Round-robin scheduler that shares one AES-128 encryption core among `NREQ` requesters. It accepts a (key, plaintext) pair from one requester at a time and drives the core's one-cycle load strobe. It then waits for the core's one-cycle done pulse and returns the ciphertext on a single response channel tagged with the requester index. It sits directly above the cipher core and is the only agent allowed to drive its `ld`, `key` and `text_in`.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, 3: width of `rsp_id`; must satisfy 2^IDW >= NREQ.
- `TIMEOUT`, 16: cycles allowed from core load to `core_done` before an error response.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  one-hot accept; a request transfers when `req_valid[i] & req_ready[i]`.
- `req_key`  in  NREQ*128  key of requester i is at [128*i+127:128*i].
- `req_text`  in  NREQ*128  plaintext, packed the same way.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  IDW  index of the requester being answered.
- `rsp_data`  out  128  ciphertext.
- `rsp_err`  out  1  timeout indication; `rsp_data` is 0 when set.
- `core_ld`  out  1  load strobe to the core.
- `core_key`  out  128  key to the core; registered.
- `core_text`  out  128  plaintext to the core; registered.
- `core_done`  in  1  core completion pulse.
- `core_text_out`  in  128  core ciphertext, valid in the cycle `core_done` is high.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, LOAD, BUSY, RESP.
- IDLE, when any `req_valid` is high:
  - grant the first set bit at or after `rr_ptr`, searching upward with wrap.
  - `req_ready` for the granted requester is high combinationally in that cycle; all other bits are 0.
  - capture the granted key and text into `core_key`/`core_text` and the index into `cur_id`.
  - set `rr_ptr` to (grant+1) mod NREQ, then go to LOAD.
- LOAD: `core_ld`=1 for exactly one cycle; clear the timeout counter; go to BUSY.
- BUSY:
  - on `core_done`: latch `core_text_out` into `rsp_data`, set `rsp_err`=0, go to RESP.
  - otherwise increment the counter; when it reaches TIMEOUT-1 without `core_done`, set `rsp_data`=0 and `rsp_err`=1, go to RESP.
- RESP:
  - `rsp_valid`=1 with `rsp_id`=`cur_id`; `rsp_id`, `rsp_data` and `rsp_err` are held stable while `rsp_valid & !rsp_ready`.
  - on `rsp_ready`, go to IDLE.
- `req_ready` is 0 in all states except IDLE, so there is exactly one transaction in flight.
- `core_done` in IDLE, LOAD or RESP is ignored and causes no response.
- `core_ld` is never asserted while the core is running.
- `rr_ptr` advances only on a grant; requesters that drop `req_valid` before a grant are not penalised.
- Only encryption is sequenced; key expansion is reloaded on every `core_ld`.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `core_ld`=0, `core_key`=0, `core_text`=0, `busy`=0, state=IDLE, `rr_ptr`=0, counter=0.
- Reset while in LOAD, BUSY or RESP: return to IDLE and drop the pending response.
  - The core shares `rst`, so it is cleared in the same cycle.
- Accept in cycle A; `core_ld` is high in A+1.
- The core raises `core_done` in A+13, which is 12 cycles after `core_ld`.
- `rsp_valid` rises in A+14.
- With `rsp_ready` held high, the next grant can occur in A+15, so back-to-back throughput is one block per 15 cycles.
- The timeout error response has `rsp_valid` rising TIMEOUT+1 cycles after `core_ld`.
- `core_key` and `core_text` stay stable from A+1 until the next accept.

## Test plan
- Single request: requester 2 sends key 000102..0f and plaintext 00112233..eeff.
  - Required: exactly one `core_ld`, in A+1.
  - Required: `rsp_valid` in A+14 with `rsp_id`=2, `rsp_data`=69c4e0d86a7b0430d8cdb78070b4c55a, `rsp_err`=0.
- All four `req_valid` high continuously, `rsp_ready`=1:
  - grant order is 0,1,2,3,0.
  - consecutive accepts are 15 cycles apart.
  - exactly one `req_ready` bit is set per accept.
- Backpressure: hold `rsp_ready`=0 for 20 cycles in RESP.
  - `rsp_valid`, `rsp_id` and `rsp_data` stay stable throughout.
  - `req_ready` stays 0 although requester 1 is valid.
  - requester 1 is granted the cycle after `rsp_ready` goes high.
- Timeout: the bench model withholds `core_done`.
  - `rsp_err`=1 and `rsp_data`=0 appear TIMEOUT+1 cycles after `core_ld`.
  - a later request completes normally.
- Spurious `core_done` pulse while in IDLE:
  - no response is produced, state is unchanged.
- Reset asserted in BUSY:
  - all outputs return to their reset values at the next edge.
  - the late `core_done` produces no response.
  - after release, requester 0 is granted first.
